uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with a 2-flop rx synchronizer.
// Optional even-parity bit and parity_err port when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            rx,
    output logic [DBIT-1:0] data,
    output logic            rx_done,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int            NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_n;
    logic [3:0]      s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic [DBIT-1:0] data_n;
    logic            fe_n, done_n;
    logic            rx_q1, rx_s;
`ifdef UART_RX_PARITY_EN
    logic            p, p_n, pe_n;
`endif

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            data      <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p          <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            s         <= s_n;
            n         <= n_n;
            b         <= b_n;
            data      <= data_n;
            rx_done   <= done_n;
            frame_err <= fe_n;
`ifdef UART_RX_PARITY_EN
            p          <= p_n;
            parity_err <= pe_n;
`endif
        end
    end

    // Next-state and datapath decode; rx_done is registered, so it rises one clk after the final stop tick.
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        data_n  = data;
        fe_n    = frame_err;
        done_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_n     = p;
        pe_n    = parity_err;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == 4'd7) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        s_n = '0;
                        b_n = DBIT'({rx_s, b} >> 1);
                        if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_n = n + 1'b1;
                        end
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        s_n     = '0;
                        p_n     = rx_s;
                        state_n = STOP;
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s == SB_LAST) begin
                        state_n = IDLE;
                        data_n  = b;
                        fe_n    = ~rx_s;
                        done_n  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        pe_n    = (^b) ^ p;
`endif
                    end else begin
                        s_n = s + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
